// File: rtl/seq_div_if.sv
// rtl/seq_div_if.sv - request/result bundle for the sequential divider
interface seq_div_if #(
   parameter int NUM_W = 16,
   parameter int DEN_W = 5
);
   logic             start;
   logic [NUM_W-1:0] num;
   logic [DEN_W-1:0] den;
   logic             ready;
   logic             valid;
   logic [NUM_W-1:0] quot;
   logic [DEN_W-1:0] rem;
   logic             dbz;

   modport master (
      output start, num, den,
      input  ready, valid, quot, rem, dbz
   );

   modport slave (
      input  start, num, den,
      output ready, valid, quot, rem, dbz
   );
endinterface

// File: rtl/seq_div.sv
// rtl/seq_div.sv - unsigned restoring divider, one quotient bit per cycle
module seq_div #(
   parameter int NUM_W = 16,
   parameter int DEN_W = 5
) (
   input logic      clk,
   input logic      rst,
   seq_div_if.slave io
);
   localparam int CNT_W = $clog2(NUM_W + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_W - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q;
   logic [NUM_W-1:0] work_q;
   logic [DEN_W-1:0] den_q;
   logic [DEN_W-1:0] prem_q;
   logic [CNT_W-1:0] cnt_q;
   logic             ready_q;
   logic             valid_q;
   logic             dbz_q;

   logic [DEN_W:0]   trial_d;
   logic             qbit_d;
   logic [DEN_W-1:0] prem_d;
   logic [NUM_W-1:0] work_d;

   // work_q starts as the dividend and fills with quotient bits from the LSB end;
   // the restored remainder is always below den, so DEN_W bits hold it.
   always_comb begin
      trial_d = {prem_q, work_q[NUM_W-1]};
      qbit_d  = (trial_d >= {1'b0, den_q});
      prem_d  = qbit_d ? (trial_d[DEN_W-1:0] - den_q) : trial_d[DEN_W-1:0];
      work_d  = {work_q[NUM_W-2:0], qbit_d};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         work_q  <= '0;
         den_q   <= '0;
         prem_q  <= '0;
         cnt_q   <= '0;
         ready_q <= 1'b1;
         valid_q <= 1'b0;
         dbz_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (io.start) begin
                  cnt_q   <= '0;
                  den_q   <= io.den;
                  prem_q  <= '0;
                  ready_q <= 1'b0;
                  if (io.den == '0) begin
                     work_q  <= '1;
                     dbz_q   <= 1'b1;
                     valid_q <= 1'b1;
                     state_q <= DONE;
                  end else begin
                     work_q  <= io.num;
                     dbz_q   <= 1'b0;
                     state_q <= RUN;
                  end
               end
            end
            RUN: begin
               work_q <= work_d;
               prem_q <= prem_d;
               cnt_q  <= cnt_q + 1'b1;
               if (cnt_q == LAST_CNT) begin
                  valid_q <= 1'b1;
                  state_q <= DONE;
               end
            end
            DONE: begin
               valid_q <= 1'b0;
               ready_q <= 1'b1;
               state_q <= IDLE;
            end
            default: begin
               valid_q <= 1'b0;
               ready_q <= 1'b1;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign io.ready = ready_q;
   assign io.valid = valid_q;
   assign io.quot  = work_q;
   assign io.rem   = prem_q;
   assign io.dbz   = dbz_q;
endmodule

// File: tb/tb_seq_div.sv
// tb/tb_seq_div.sv - randomized self-checking bench for seq_div against an arithmetic model
module tb_seq_div;
   localparam int NUM_W = 16;
   localparam int DEN_W = 5;
   localparam int N_RAND = 2000;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   seq_div_if #(.NUM_W(NUM_W), .DEN_W(DEN_W)) io ();

   seq_div #(.NUM_W(NUM_W), .DEN_W(DEN_W)) dut (
      .clk (clk),
      .rst (rst),
      .io  (io)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_quot(input logic [31:0] n, input logic [31:0] d);
      return (d == 0) ? 32'(16'hFFFF) : n / d;
   endfunction

   function automatic logic [31:0] model_rem(input logic [31:0] n, input logic [31:0] d);
      return (d == 0) ? 32'd0 : n % d;
   endfunction

   // Starts at a negedge with the DUT idle; ends at the negedge right after the valid cycle.
   task automatic run_op(input logic [NUM_W-1:0] n, input logic [DEN_W-1:0] d);
      int          lat;
      logic [31:0] eq;
      logic [31:0] er;
      eq = model_quot(32'(n), 32'(d));
      er = model_rem(32'(n), 32'(d));
      check("ready_before_start", 32'(io.ready), 32'd1);
      io.start = 1'b1;
      io.num   = n;
      io.den   = d;
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      io.start = 1'b0;
      io.num   = NUM_W'($urandom);
      io.den   = DEN_W'($urandom);
      while (!io.valid && lat < 100) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      check("latency", 32'(lat), (d == 0) ? 32'd1 : 32'(NUM_W + 1));
      check("quot", 32'(io.quot), eq);
      check("rem", 32'(io.rem), er);
      check("dbz", 32'(io.dbz), (d == 0) ? 32'd1 : 32'd0);
      check("ready_in_done", 32'(io.ready), 32'd0);
      if (d != 0) begin
         check("identity", 32'(io.quot) * 32'(d) + 32'(io.rem), 32'(n));
         check("rem_below_den", 32'(io.rem < d), 32'd1);
      end
      @(posedge clk);
      @(negedge clk);
      check("valid_one_cycle", 32'(io.valid), 32'd0);
      check("ready_after_done", 32'(io.ready), 32'd1);
      check("quot_held", 32'(io.quot), eq);
      check("rem_held", 32'(io.rem), er);
   endtask

   initial begin
      int prev;
      int nv;
      int stray;
      logic [NUM_W-1:0] rn;
      logic [DEN_W-1:0] rd;

      n_checks = 0;
      n_errors = 0;
      rst      = 1'b1;
      io.start = 1'b0;
      io.num   = '0;
      io.den   = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ready", 32'(io.ready), 32'd1);
      check("rst_valid", 32'(io.valid), 32'd0);
      check("rst_quot", 32'(io.quot), 32'd0);
      check("rst_rem", 32'(io.rem), 32'd0);
      check("rst_dbz", 32'(io.dbz), 32'd0);
      rst = 1'b0;

      run_op(16'd1000, 5'd10);
      run_op(16'd65535, 5'd31);
      run_op(16'd0, 5'd7);
      run_op(16'd100, 5'd0);
      run_op(16'd12345, 5'd1);
      run_op(16'hFFFF, 5'd1);
      run_op(16'd0, 5'd31);
      run_op(16'd30, 5'd31);

      // start held high: one result every NUM_W+2 cycles, mid-run operand noise ignored
      io.start = 1'b1;
      io.num   = 16'd370;
      io.den   = 5'd10;
      prev     = -1;
      nv       = 0;
      for (int cyc = 0; cyc < 4 * (NUM_W + 2) + 5; cyc++) begin
         @(posedge clk);
         @(negedge clk);
         if (io.valid) begin
            check("hold_quot", 32'(io.quot), 32'd37);
            check("hold_rem", 32'(io.rem), 32'd0);
            if (prev >= 0) check("hold_period", 32'(cyc - prev), 32'(NUM_W + 2));
            prev = cyc;
            nv++;
            io.num = 16'd370;
            io.den = 5'd10;
         end else if (prev >= 0 && cyc - prev >= 2) begin
            io.num = NUM_W'($urandom);
            io.den = DEN_W'($urandom);
         end
      end
      check("hold_results", 32'(nv), 32'd4);
      io.start = 1'b0;

      // abort 5 cycles into RUN
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      io.start = 1'b1;
      io.num   = 16'd1000;
      io.den   = 5'd10;
      @(posedge clk);
      @(negedge clk);
      io.start = 1'b0;
      repeat (4) begin
         @(posedge clk);
         @(negedge clk);
      end
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("abort_ready", 32'(io.ready), 32'd1);
      check("abort_valid", 32'(io.valid), 32'd0);
      check("abort_quot", 32'(io.quot), 32'd0);
      check("abort_rem", 32'(io.rem), 32'd0);
      check("abort_dbz", 32'(io.dbz), 32'd0);
      rst   = 1'b0;
      stray = 0;
      repeat (NUM_W + 4) begin
         @(posedge clk);
         @(negedge clk);
         if (io.valid) stray++;
      end
      check("abort_no_valid", 32'(stray), 32'd0);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      run_op(16'd999, 5'd9);

      for (int i = 0; i < N_RAND; i++) begin
         rn = NUM_W'($urandom);
         case ($urandom_range(0, 7))
            0: rn = '0;
            1: rn = '1;
            default: ;
         endcase
         rd = DEN_W'($urandom_range(1, (1 << DEN_W) - 1));
         case ($urandom_range(0, 15))
            0: rd = '0;
            1: rd = 5'd1;
            2: rd = '1;
            default: ;
         endcase
         run_op(rn, rd);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
